// File: rtl/hcf_pkg.sv
// Shared types and constants for the subtraction-based HCF (GCD) engine.
package hcf_pkg;

  localparam int WIDTH_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    CALC,
    DONE
  } state_e;

  // Source selected for an operand register when its load enable is high.
  typedef enum logic [1:0] {
    SEL_DATA,
    SEL_DIFF,
    SEL_OR
  } sel_e;

endpackage

// File: rtl/hcf_datapath.sv
// Operand registers, input muxing, subtractor and comparator for hcf_engine.
module hcf_datapath
  import hcf_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ldA_i,
  input  logic             ldB_i,
  input  logic [1:0]       selIn_i,
  input  logic             subDir_i,
  input  logic [WIDTH-1:0] dataIn_i,
  output logic [WIDTH-1:0] opA_o,
  output logic             lt_o,
  output logic             gt_o,
  output logic             eq_o,
  output logic             aZero_o,
  output logic             bZero_o
);

  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic [WIDTH-1:0] diff;

  // subDir_i selects B-A instead of A-B; the controller only asks for larger minus smaller.
  always_comb begin
    diff  = subDir_i ? (opB_q - opA_q) : (opA_q - opB_q);
    opA_d = opA_q;
    opB_d = opB_q;
    if (ldA_i) begin
      if (selIn_i == SEL_DATA)      opA_d = dataIn_i;
      else if (selIn_i == SEL_DIFF) opA_d = diff;
      else                          opA_d = opA_q | opB_q;
    end
    if (ldB_i) begin
      opB_d = (selIn_i == SEL_DATA) ? dataIn_i : diff;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opA_q <= '0;
      opB_q <= '0;
    end else begin
      opA_q <= opA_d;
      opB_q <= opB_d;
    end
  end

  assign opA_o   = opA_q;
  assign lt_o    = opA_q < opB_q;
  assign gt_o    = opA_q > opB_q;
  assign eq_o    = opA_q == opB_q;
  assign aZero_o = opA_q == '0;
  assign bZero_o = opB_q == '0;

endmodule

// File: rtl/hcf_engine.sv
// Iterative GCD by repeated subtraction: serial operand load, FSM controller
// driving hcf_datapath, four-phase start/done handshake.
module hcf_engine
  import hcf_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             done,
  output logic             busy,
  output logic [WIDTH-1:0] hcf_out
);

  state_e           state_q, state_d;
  logic             ldA, ldB, subDir;
  logic [1:0]       selIn;
  logic [WIDTH-1:0] opA;
  logic             lt, gt, eq, aZero, bZero;

  hcf_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk      (clk),
    .rst      (rst),
    .ldA_i    (ldA),
    .ldB_i    (ldB),
    .selIn_i  (selIn),
    .subDir_i (subDir),
    .dataIn_i (data_in),
    .opA_o    (opA),
    .lt_o     (lt),
    .gt_o     (gt),
    .eq_o     (eq),
    .aZero_o  (aZero),
    .bZero_o  (bZero)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Zero check precedes the equality check so gcd(x,0)=x resolves in one step.
  always_comb begin
    state_d = state_q;
    ldA     = 1'b0;
    ldB     = 1'b0;
    selIn   = SEL_DATA;
    subDir  = 1'b0;
    unique case (state_q)
      IDLE:   if (start) state_d = LOAD_A;
      LOAD_A: begin
        ldA     = 1'b1;
        state_d = LOAD_B;
      end
      LOAD_B: begin
        ldB     = 1'b1;
        state_d = CALC;
      end
      CALC: begin
        if (aZero || bZero) begin
          ldA     = 1'b1;
          selIn   = SEL_OR;
          state_d = DONE;
        end else if (eq) begin
          state_d = DONE;
        end else if (gt) begin
          ldA   = 1'b1;
          selIn = SEL_DIFF;
        end else if (lt) begin
          ldB    = 1'b1;
          selIn  = SEL_DIFF;
          subDir = 1'b1;
        end
      end
      DONE:    if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign done    = state_q == DONE;
  assign busy    = (state_q == LOAD_A) || (state_q == LOAD_B) || (state_q == CALC);
  assign hcf_out = done ? opA : '0;

endmodule

// File: tb/tb_hcf_engine.sv
// Directed self-checking bench for hcf_engine with hand-computed GCDs and latencies.
module tb_hcf_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] data_in;
  logic        done;
  logic        busy;
  logic [15:0] hcf_out;

  int assertCount = 0;
  int failCount   = 0;

  hcf_engine #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .data_in (data_in),
    .done    (done),
    .busy    (busy),
    .hcf_out (hcf_out)
  );

  always #5 clk = ~clk;

  // Starts a run from IDLE: start seen at edge 0, A at edge 1, B at edge 2.
  // Returns the edge index after which done was first seen (-1 on timeout).
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               output int doneEdge, output logic busyLoad);
    start   = 1'b1;
    data_in = a;
    @(posedge clk); #1;
    busyLoad = busy;
    @(posedge clk); #1;
    busyLoad = busyLoad & busy;
    data_in  = b;
    @(posedge clk); #1;
    busyLoad = busyLoad & busy;
    data_in  = 16'hFFFF;
    doneEdge = -1;
    for (int k = 3; k < 300; k++) begin
      @(posedge clk); #1;
      if (done) begin
        doneEdge = k;
        break;
      end
    end
  endtask

  task automatic dropStart();
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    start   = 1'b0;
    data_in = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    assertCount++;
    if ({done, busy, hcf_out} !== 18'h0) begin
      failCount++;
      $display("[TB] FAIL reset_outputs: done=%b busy=%b hcf_out=%0d, want 0/0/0", done, busy, hcf_out);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    assertCount++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL idle_no_start: done=%b busy=%b, want 0/0", done, busy);
    end
  endtask

  task automatic test_basic();
    int e; logic bl;
    applyStimulus(16'd143, 16'd78, e, bl);
    assertCount++;
    if (bl !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL basic_busy: busy through load/calc=%b, want 1", bl);
    end
    assertCount++;
    if (e !== 9) begin
      failCount++;
      $display("[TB] FAIL basic_latency: done after edge %0d, want 9", e);
    end
    assertCount++;
    if (hcf_out !== 16'd13 || busy !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL basic_result: hcf_out=%0d busy=%b, want 13/0", hcf_out, busy);
    end
    repeat (3) @(posedge clk);
    #1;
    assertCount++;
    if (done !== 1'b1 || hcf_out !== 16'd13) begin
      failCount++;
      $display("[TB] FAIL basic_hold: done=%b hcf_out=%0d, want 1/13", done, hcf_out);
    end
    dropStart();
  endtask

  task automatic test_release();
    int e; logic bl;
    applyStimulus(16'd48, 16'd18, e, bl);
    assertCount++;
    if (e !== 7 || hcf_out !== 16'd6) begin
      failCount++;
      $display("[TB] FAIL release_result: edge=%0d hcf_out=%0d, want 7/6", e, hcf_out);
    end
    dropStart();
    assertCount++;
    if ({done, busy, hcf_out} !== 18'h0) begin
      failCount++;
      $display("[TB] FAIL release_idle: done=%b busy=%b hcf_out=%0d, want 0/0/0", done, busy, hcf_out);
    end
  endtask

  task automatic test_equal();
    int e; logic bl;
    applyStimulus(16'd7, 16'd7, e, bl);
    assertCount++;
    if (e !== 3 || hcf_out !== 16'd7) begin
      failCount++;
      $display("[TB] FAIL equal_operands: edge=%0d hcf_out=%0d, want 3/7", e, hcf_out);
    end
    dropStart();
  endtask

  task automatic test_zero();
    int e; logic bl;
    applyStimulus(16'd0, 16'd25, e, bl);
    assertCount++;
    if (e !== 3 || hcf_out !== 16'd25) begin
      failCount++;
      $display("[TB] FAIL zero_a: edge=%0d hcf_out=%0d, want 3/25", e, hcf_out);
    end
    dropStart();
    applyStimulus(16'd0, 16'd0, e, bl);
    assertCount++;
    if (e !== 3 || done !== 1'b1 || hcf_out !== 16'd0) begin
      failCount++;
      $display("[TB] FAIL zero_both: edge=%0d done=%b hcf_out=%0d, want 3/1/0", e, done, hcf_out);
    end
    dropStart();
  endtask

  task automatic test_coprime();
    int e; logic bl;
    applyStimulus(16'd17, 16'd5, e, bl);
    assertCount++;
    if (e !== 9 || hcf_out !== 16'd1) begin
      failCount++;
      $display("[TB] FAIL coprime: edge=%0d hcf_out=%0d, want 9/1", e, hcf_out);
    end
    dropStart();
  endtask

  task automatic test_back_to_back();
    int e; logic bl;
    applyStimulus(16'd100, 16'd75, e, bl);
    assertCount++;
    if (hcf_out !== 16'd25) begin
      failCount++;
      $display("[TB] FAIL b2b_first: hcf_out=%0d, want 25", hcf_out);
    end
    dropStart();
    applyStimulus(16'd21, 16'd14, e, bl);
    assertCount++;
    if (e !== 5 || hcf_out !== 16'd7) begin
      failCount++;
      $display("[TB] FAIL b2b_second: edge=%0d hcf_out=%0d, want 5/7", e, hcf_out);
    end
    dropStart();
  endtask

  task automatic test_mid_reset();
    int e; logic bl;
    start   = 1'b1;
    data_in = 16'd143;
    @(posedge clk); #1;
    @(posedge clk); #1;
    data_in = 16'd78;
    repeat (3) @(posedge clk);
    #1;
    assertCount++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL midreset_calc: busy=%b done=%b, want 1/0", busy, done);
    end
    rst   = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    assertCount++;
    if ({done, busy, hcf_out} !== 18'h0) begin
      failCount++;
      $display("[TB] FAIL midreset_idle: done=%b busy=%b hcf_out=%0d, want 0/0/0", done, busy, hcf_out);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(16'd143, 16'd78, e, bl);
    assertCount++;
    if (e !== 9 || hcf_out !== 16'd13) begin
      failCount++;
      $display("[TB] FAIL midreset_rerun: edge=%0d hcf_out=%0d, want 9/13", e, hcf_out);
    end
    dropStart();
  endtask

  initial begin
    $display("[TB] hcf_engine directed tests starting");
    test_reset();
    test_basic();
    test_release();
    test_equal();
    test_zero();
    test_coprime();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
